// File: rtl/cbus_sram_responder_pkg.sv
// Shared types for the simplified burst cache bus (cbus) and its SRAM responder.
//   cbus_req_t  (77 bits): valid, is_write, size, addr, strobe, data, len
//   cbus_resp_t (34 bits): ready, last, data
//   cbus_slv_state_t     : responder FSM states
package cbus_sram_responder_pkg;

    typedef logic [31:0] view_t;     // one 32-bit bus word
    typedef logic [3:0]  strobe_t;   // byte-write enables, bit i covers data[8*i +: 8]
    typedef logic [2:0]  msize_t;    // access size, informational only for this responder

    // Burst length encoded as beats-1.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,  MLEN2  = 4'd1,  MLEN3  = 4'd2,  MLEN4  = 4'd3,
        MLEN5  = 4'd4,  MLEN6  = 4'd5,  MLEN7  = 4'd6,  MLEN8  = 4'd7,
        MLEN9  = 4'd8,  MLEN10 = 4'd9,  MLEN11 = 4'd10, MLEN12 = 4'd11,
        MLEN13 = 4'd12, MLEN14 = 4'd13, MLEN15 = 4'd14, MLEN16 = 4'd15
    } mlen_t;

    typedef struct packed {
        logic    valid;
        logic    is_write;
        msize_t  size;
        view_t   addr;
        strobe_t strobe;
        view_t   data;
        mlen_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        view_t data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        CS_IDLE,
        CS_WAIT,
        CS_BURST,
        CS_DONE
    } cbus_slv_state_t;

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port word-addressed SRAM with per-byte write enables and a registered
// (synchronous) read port.
//   clk   : clock
//   en    : access enable (read when we=0, write when we=1)
//   we    : write enable
//   be    : byte enables for writes
//   addr  : word index
//   wdata : write data
//   rdata : read data, valid the cycle after a read access; held otherwise
module sram_1rw_be #(
    parameter int unsigned WORDS = 4096
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(WORDS)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [WORDS];

    // NOTE: the array and its read register have no reset: contents must survive
    // resetn, and a reset on a memory array prevents mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/cbus_sram_responder.sv
// Memory-side cbus responder: serves single and INCR burst reads/writes from an
// on-chip SRAM of MEM_WORDS 32-bit words. LATENCY idle cycles separate request
// acceptance from the first beat; beats then stream one per cycle.
//   clk       : clock, all logic on posedge
//   resetn    : asynchronous active-low reset (SRAM contents are kept)
//   creq      : cbus request from the initiator
//   cresp     : cbus response (ready/last/data)
//   busy      : transaction in progress
//   proto_err : one-cycle pulse after valid was dropped before the last beat
module cbus_sram_responder
    import cbus_sram_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output logic       busy,
    output logic       proto_err
);

    localparam int unsigned ADDR_W = $clog2(MEM_WORDS);
    localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef logic [ADDR_W-1:0] idx_t;

    cbus_slv_state_t state, state_next;

    logic [LAT_W-1:0] lat_cnt;
    logic [3:0]       beat;
    idx_t             base_idx;
    mlen_t            len_q;
    logic             wr_q;

    logic  lat_done;
    logic  last_beat;
    logic  abort;
    idx_t  cur_idx;
    idx_t  next_idx;

    logic        sram_en;
    logic        sram_we;
    idx_t        sram_addr;
    logic [31:0] sram_rdata;

    // Address bits outside the word index and the size field are not used.
    logic unused_req_bits;
    assign unused_req_bits = ^{creq.size, creq.addr[31:ADDR_W+2], creq.addr[1:0]};

    // Index arithmetic is ADDR_W wide, so bursts wrap at the end of the array.
    assign cur_idx   = base_idx + idx_t'(beat);
    assign next_idx  = cur_idx + idx_t'(1);
    assign lat_done  = (lat_cnt == LAT_W'(LATENCY - 1));
    assign last_beat = (beat == 4'(len_q));
    assign busy      = (state != CS_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of block evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= CS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cresp      = '0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = cur_idx;
        abort      = 1'b0;

        case (state)
            CS_IDLE: begin
                if (creq.valid) begin
                    state_next = CS_WAIT;
                end
            end

            CS_WAIT: begin
                if (!creq.valid) begin
                    abort      = 1'b1;
                    state_next = CS_IDLE;
                end else if (lat_done) begin
                    // Prefetch beat 0 so its data is on rdata in the first burst cycle.
                    sram_en    = !wr_q;
                    sram_addr  = base_idx;
                    state_next = CS_BURST;
                end
            end

            CS_BURST: begin
                cresp.ready = 1'b1;
                cresp.last  = last_beat;
                cresp.data  = wr_q ? '0 : sram_rdata;
                if (!creq.valid) begin
                    abort      = 1'b1;
                    state_next = CS_IDLE;
                end else begin
                    if (wr_q) begin
                        sram_en = 1'b1;
                        sram_we = 1'b1;
                    end else begin
                        // Read one beat ahead to hide the synchronous read latency.
                        sram_en   = !last_beat;
                        sram_addr = next_idx;
                    end
                    if (last_beat) begin
                        state_next = CS_DONE;
                    end
                end
            end

            CS_DONE: begin
                // Valid is ignored here so the initiator can drop it after last.
                state_next = CS_IDLE;
            end

            default: begin
                state_next = CS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_cnt   <= '0;
            beat      <= '0;
            base_idx  <= '0;
            len_q     <= MLEN1;
            wr_q      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= abort;
            case (state)
                CS_IDLE: begin
                    if (creq.valid) begin
                        base_idx <= creq.addr[ADDR_W+1:2];
                        len_q    <= creq.len;
                        wr_q     <= creq.is_write;
                        lat_cnt  <= '0;
                        beat     <= '0;
                    end
                end
                CS_WAIT: begin
                    if (!lat_done) begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                CS_BURST: begin
                    beat <= beat + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    sram_1rw_be #(
        .WORDS (MEM_WORDS)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .be    (creq.strobe),
        .addr  (sram_addr),
        .wdata (creq.data),
        .rdata (sram_rdata)
    );

endmodule
